// File: rtl/imem_loader.sv
// Byte-stream program loader: frames count/words/checksum
// into imem writes and holds the core in reset until done.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   start                   begin a load (IDLE/DONE/ERR only)
//   in_valid/in_data        stream byte, in_ready accepts
//   imem_we/addr/wdata      instruction memory write port
//   cpu_reset               core hold, low only in DONE
//   done/error              load result flags
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, nxt_state;

  logic [ADDR_W-1:0] last, nxt_last;
  logic [ADDR_W-1:0] nxt_addr;
  logic [15:0]       nxt_wdata;
  logic [7:0]        csum, nxt_csum;
  logic              xfer;
  logic              cnt_bad;

  // in_ready is a register that mirrors the byte-accepting
  // states, so it is also the transfer qualifier.
  assign xfer = in_valid && in_ready;

  assign cnt_bad = (in_data == 8'd0) ||
                   (32'(in_data) > DEPTH);

  always_comb begin
    nxt_state = state;
    nxt_last  = last;
    nxt_addr  = imem_addr;
    nxt_wdata = imem_wdata;
    nxt_csum  = csum;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) nxt_state = S_COUNT;
      end
      S_COUNT: begin
        if (xfer) begin
          if (cnt_bad) begin
            nxt_state = S_ERR;
          end else begin
            // N == DEPTH wraps to 0 in the low bits,
            // so minus one still lands on DEPTH-1.
            nxt_last  = in_data[ADDR_W-1:0] - ADDR_W'(1);
            nxt_addr  = '0;
            nxt_csum  = '0;
            nxt_state = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          nxt_wdata[15:8] = in_data;
          nxt_csum        = csum ^ in_data;
          nxt_state       = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          nxt_wdata[7:0] = in_data;
          nxt_csum       = csum ^ in_data;
          nxt_state      = S_WRITE;
        end
      end
      S_WRITE: begin
        if (imem_addr == last) begin
          nxt_state = S_CHECK;
        end else begin
          nxt_addr  = imem_addr + ADDR_W'(1);
          nxt_state = S_HI;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data == csum) nxt_state = S_DONE;
          else                 nxt_state = S_ERR;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  logic nxt_ready;
  logic nxt_we;
  logic nxt_done;
  logic nxt_err;

  // Outputs are registered from the next state so they
  // line up with the state they describe.
  always_comb begin
    nxt_ready = (nxt_state == S_COUNT) ||
                (nxt_state == S_HI)    ||
                (nxt_state == S_LO)    ||
                (nxt_state == S_CHECK);
    nxt_we    = (nxt_state == S_WRITE);
    nxt_done  = (nxt_state == S_DONE);
    nxt_err   = (nxt_state == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last       <= '0;
      csum       <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= nxt_state;
      last       <= nxt_last;
      csum       <= nxt_csum;
      in_ready   <= nxt_ready;
      imem_we    <= nxt_we;
      imem_addr  <= nxt_addr;
      imem_wdata <= nxt_wdata;
      cpu_reset  <= !nxt_done;
      done       <= nxt_done;
      error      <= nxt_err;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table rows,
// random frames vs. a frame-level model, reset mid-load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] mode;
    logic       bad;
    logic [6:0] pct;
    logic       done;
    logic       err;
    logic [4:0] nw;
  } vec_t;

  int total = 0;
  int bad = 0;
  int ovl = 0;

  logic [7:0]  fr[$];
  logic [19:0] obs[$];
  logic [19:0] exp_q[$];
  logic [15:0] obs_mem[16];
  logic [15:0] exp_mem[16];
  logic [15:0] nom[4];
  logic        prev_we = 1'b0;
  vec_t        tbl[9];

  // Write monitor: one record per WRITE cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      obs.push_back({imem_addr, imem_wdata});
      obs_mem[imem_addr] = imem_wdata;
      if (in_ready || prev_we) ovl++;
    end
    prev_we = imem_we;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    logic [7:0]  x;
    logic [15:0] w;
    fr.delete();
    fr.push_back(v.cnt);
    if (v.cnt == 8'd0 || v.cnt > 8'd16) return;
    x = 8'd0;
    for (int i = 0; i < int'(v.cnt); i++) begin
      case (v.mode)
        2'd0:    w = nom[i % 4];
        2'd1:    w = 16'(i);
        default: w = 16'($urandom);
      endcase
      fr.push_back(w[15:8]);
      fr.push_back(w[7:0]);
      x ^= w[15:8] ^ w[7:0];
    end
    fr.push_back(x ^ {7'd0, v.bad});
  endtask

  // Frame-level reference: what memory should hold.
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [15:0] w;
    exp_q.delete();
    n = int'(fr[0]);
    if (n < 1 || n > 16) return;
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = {fr[1 + 2 * i], fr[2 + 2 * i]};
      exp_q.push_back({4'(i), w});
      exp_mem[i] = w;
      x ^= fr[1 + 2 * i] ^ fr[2 + 2 * i];
    end
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".start"},
        {28'd0, in_ready, done, error, cpu_reset},
        {28'd0, 4'b1001});
  endtask

  task automatic send(input string nm, input int nsend,
                      input int start_at, input int pct);
    int  i = 0;
    int  cyc = 0;
    bit  x;
    bit  sp = 1'b0;
    while (i < nsend && cyc < 400) begin
      in_valid = ($urandom_range(0, 99) < pct);
      in_data  = in_valid ? fr[i] : 8'($urandom);
      start    = (i == start_at) && !sp;
      if (start) sp = 1'b1;
      @(negedge clk);
      x = in_valid && in_ready;
      @(posedge clk); #1;
      if (x) i++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (cyc >= 400) chk({nm, ".timeout"}, 32'(i), 32'(nsend));
  endtask

  function automatic int mem_diff();
    int m = 0;
    for (int i = 0; i < 16; i++)
      if (obs_mem[i] !== exp_mem[i]) m++;
    return m;
  endfunction

  task automatic run_row(input string nm, input vec_t v);
    int base;
    int m;
    build(v);
    model();
    base = obs.size();
    do_start(nm);
    send(nm, fr.size(), (v.mode == 2'd1) ? 9 : -1,
         int'(v.pct));
    chk({nm, ".nwrites"}, 32'(obs.size() - base),
        {27'd0, v.nw});
    m = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= obs.size() ||
          obs[base + i] !== exp_q[i]) m++;
    chk({nm, ".wdata"}, 32'(m), 32'd0);
    chk({nm, ".status"},
        {28'd0, done, error, cpu_reset, in_ready},
        {28'd0, v.done, v.err, !v.done, 1'b0});
    chk({nm, ".mem"}, 32'(mem_diff()), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   c;
    nom[0] = 16'h1123;
    nom[1] = 16'h2412;
    nom[2] = 16'h3509;
    nom[3] = 16'h1655;
    tbl[0] = '{8'h04, 2'd0, 1'b0, 7'd100, 1'b1, 1'b0, 5'd4};
    tbl[1] = '{8'h04, 2'd0, 1'b1, 7'd100, 1'b0, 1'b1, 5'd4};
    tbl[2] = '{8'h00, 2'd0, 1'b0, 7'd100, 1'b0, 1'b1, 5'd0};
    tbl[3] = '{8'h11, 2'd0, 1'b0, 7'd100, 1'b0, 1'b1, 5'd0};
    tbl[4] = '{8'h04, 2'd0, 1'b0, 7'd50,  1'b1, 1'b0, 5'd4};
    tbl[5] = '{8'h10, 2'd1, 1'b0, 7'd100, 1'b1, 1'b0, 5'd16};
    tbl[6] = '{8'h01, 2'd2, 1'b0, 7'd70,  1'b1, 1'b0, 5'd1};
    tbl[7] = '{8'h10, 2'd2, 1'b0, 7'd60,  1'b1, 1'b0, 5'd16};
    tbl[8] = '{8'h07, 2'd2, 1'b1, 7'd80,  1'b0, 1'b1, 5'd7};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    chk("reset",
        {7'd0, in_ready, imem_we, imem_addr, imem_wdata,
         cpu_reset, done, error},
        {7'd0, 1'b0, 1'b0, 4'h0, 16'h0000,
         1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h04;
    @(posedge clk); #1;
    chk("idle.ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    for (int r = 0; r < 9; r++) begin
      run_row($sformatf("row%0d", r), tbl[r]);
      if (r == 0) begin
        chk("nom.a0", {16'd0, obs_mem[0]}, 32'h1123);
        chk("nom.a3", {16'd0, obs_mem[3]}, 32'h1655);
        chk("nom.ck", {24'd0, fr[fr.size() - 1]}, 32'h7b);
      end
    end

    // Reset after the second word's high byte.
    build(tbl[0]);
    c = obs.size();
    do_start("rst");
    send("rst", 4, -1, 100);
    reset = 1'b1;
    #1;
    chk("rst.async",
        {27'd0, imem_we, cpu_reset, in_ready, done, error},
        {27'd0, 5'b01000});
    chk("rst.partial", 32'(obs.size() - c), 32'd1);
    exp_mem[0] = 16'h1123;
    chk("rst.mem", 32'(mem_diff()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_row("rst.reload", tbl[0]);

    // Random frames; expectations from the framing rules.
    for (int r = 0; r < 8; r++) begin
      v.cnt  = 8'($urandom_range(0, 18));
      v.mode = 2'd2;
      v.bad  = 1'($urandom_range(0, 1));
      v.pct  = 7'($urandom_range(30, 100));
      c = (v.cnt >= 8'd1 && v.cnt <= 8'd16) ? int'(v.cnt) : 0;
      v.done = (c != 0) && !v.bad;
      v.err  = !v.done;
      v.nw   = 5'(c);
      run_row($sformatf("rnd%0d", r), v);
    end

    chk("protocol", 32'(ovl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes instruction memory for the 3-stage pipeline core. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words. Each word is written sequentially into the instruction memory's write port. The loader holds the core in reset until a load completes with a matching checksum, then releases it.

## Interface
- `DEPTH`, 16, instruction memory words; maximum program length
- `ADDR_W`, 4, instruction memory address width (log2 DEPTH)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; all state and outputs return to reset values immediately
- `start` in 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- `in_valid` in 1: stream byte valid
- `in_data` in 8: stream byte
- `in_ready` out 1: loader can accept a byte; a transfer occurs on an edge where `in_valid && in_ready`
- `imem_we` out 1: instruction memory write strobe
- `imem_addr` out ADDR_W: write address
- `imem_wdata` out 16: write data, formatted as {opcode[15:12], rd[11:8], rs1[7:4], rs2/imm[3:0]}
- `cpu_reset` out 1: core reset hold; high except in DONE
- `done` out 1: load completed, checksum good
- `error` out 1: load aborted due to a bad count or checksum mismatch

## Operation
- Frame format:
  - Count byte N, valid range 1..DEPTH.
  - Then N words, each sent as high byte first, then low byte.
  - Then one checksum byte equal to the XOR of all 2N word bytes. The count byte is excluded.
- All outputs are registered.
- States:
  - IDLE: `in_ready`=0. On `start` → COUNT.
  - COUNT: `in_ready`=1. On transfer: if N==0 or N>DEPTH → ERR. Otherwise latch N, set addr=0, clear checksum, go → HI.
  - HI: `in_ready`=1. On transfer: latch wdata[15:8], checksum ^= byte, go → LO.
  - LO: `in_ready`=1. On transfer: latch wdata[7:0], checksum ^= byte, go → WRITE.
  - WRITE: `in_ready`=0. `imem_we`=1 for exactly this one cycle, with `imem_addr`/`imem_wdata` stable. Next: if addr==N-1 → CHECK; otherwise addr+1, go → HI.
  - CHECK: `in_ready`=1. On transfer: byte==checksum → DONE, otherwise → ERR.
  - DONE: `done`=1, `cpu_reset`=0, `in_ready`=0. On `start` → COUNT.
  - ERR: `error`=1, `cpu_reset`=1, `in_ready`=0. On `start` → COUNT.
- Leaving DONE or ERR on `start` clears `done`/`error` and reasserts `cpu_reset` in the same cycle that COUNT is entered.
- `start` in COUNT/HI/LO/WRITE/CHECK is ignored; the load continues.
- The loader never wraps: `imem_addr` stops at N-1. Words beyond N are not accepted. The next byte is treated as the checksum.
- Bytes presented while `in_ready`=0 are not consumed. The upstream must hold them.
- Words not written in the current load keep their previous memory contents.

## Timing
- Reset values:
  - state=IDLE
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_reset`=1, `done`=0, `error`=0
- `in_ready` rises the cycle after the `start` edge.
- Word write latency: if the LO byte is accepted at edge k, `imem_we` is high in cycle k..k+1 and `in_ready` is low. `in_ready` returns high after edge k+1.
- Maximum throughput: 2 bytes per 3 cycles during the word phase.
- Checksum byte accepted at edge k: `done`/`error` is high and `cpu_reset` is at its final value from edge k onward.
- Reset asserted mid-load: outputs immediately return to reset values and `imem_we` drops in the same cycle. A partial program remains in memory and the core stays held.

## Test plan
- Nominal load: `start`, then bytes 04, 11,23, 24,12, 35,09, 16,55, 7B with `in_valid` held high. Required: four `imem_we` pulses writing addr0=0x1123, addr1=0x2412, addr2=0x3509, addr3=0x1655; `done`=1; `cpu_reset` falls after the 7B byte.
- Bad checksum: the same frame with checksum 7A. Required: all four writes occur, then `error`=1, `cpu_reset` stays 1, `done`=0.
- Bad count: count byte 00, then separately count byte 11 (17). Required: ERR right after the count byte, no `imem_we` pulse, `in_ready`=0.
- Backpressure/gaps: the nominal frame with `in_valid` toggled pseudo-randomly. Required: identical writes and `done`. No byte is lost or duplicated. `in_ready` is never high during WRITE.
- Maximum length: count 10 (hex, =16) with 32 bytes of words 0x0000..0x000F plus correct checksum 00. Required: writes to addr0..addr15 in order, `done`=1. A `start` pulse mid-load is ignored.
- Reset mid-load: assert `reset` after the second word's HI byte. Required: immediate `imem_we`=0, `cpu_reset`=1, `in_ready`=0. A subsequent `start` plus the nominal frame loads correctly.
